// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
// ---------------------------------------------------------------------------
// Burst access controller placed directly in front of a synchronous single
// port RAM (2^DEPTH_LOG2 x WIDTH). One command describes a whole read or write
// burst. Write data arrives on a valid/ready stream and read data leaves
// through a 4-entry FIFO, so the client never drives the RAM pins itself.
//
// Handshake rule for every stream (cmd, wr, rd): a transfer happens on the
// rising clock edge where both valid and ready are high. A valid that has been
// raised holds its payload until that edge.
//
// Ports
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o command handshake
//   cmd_wr_i                1 = write burst, 0 = read burst
//   cmd_addr_i, cmd_len_i   start address, beats minus one
//   wr_valid_i/wr_ready_o   write data handshake, wr_data_i payload
//   rd_valid_o/rd_ready_i   read data handshake, rd_data_o payload (FIFO head)
//   busy_o                  burst in progress (FSM not in IDLE)
//   ram_wr_o, ram_address_o, ram_data_o  registered RAM controls
//   ram_out_i               RAM read data
//   csum_o, csum_valid_o    burst checksum and one-cycle strobe
//   state_o                 FSM state, for debug and checkers
//
// Build option: define RAM_BURST_CSUM_EN to enable the XOR burst checksum.
// Without it csum_o and csum_valid_o are tied to zero.
// ---------------------------------------------------------------------------
module ram_burst_ctrl #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [DEPTH_LOG2-1:0] cmd_addr_i,
    input  logic [DEPTH_LOG2-1:0] cmd_len_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [WIDTH-1:0]      wr_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  busy_o,
    output logic                  ram_wr_o,
    output logic [DEPTH_LOG2-1:0] ram_address_o,
    output logic [WIDTH-1:0]      ram_data_o,
    input  logic [WIDTH-1:0]      ram_out_i,
    output logic [WIDTH-1:0]      csum_o,
    output logic                  csum_valid_o,
    output logic [1:0]            state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = 1;

    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [DEPTH_LOG2-1:0] len_q, len_d;
    logic [DEPTH_LOG2-1:0] beat_q, beat_d;
    logic                  ram_wr_q, ram_wr_d;
    logic [DEPTH_LOG2-1:0] ram_address_q, ram_address_d;
    logic [WIDTH-1:0]      ram_data_q, ram_data_d;

    // Read pipeline: bit 0 = address issued last edge, bit 1 = RAM output
    // valid now and captured into the FIFO on the coming edge.
    logic [1:0]            rd_pipe_q, rd_pipe_d;
    logic                  issue;

    logic [WIDTH-1:0]      fifo_q [4];
    logic [1:0]            wptr_q, rptr_q;
    logic [2:0]            count_q;

    logic                  cmd_hs, wr_hs, rd_hs, push;
    logic [2:0]            inflight;
    logic                  can_issue;

    assign cmd_ready_o   = (state_q == S_IDLE) && rst_n_i;
    assign wr_ready_o    = (state_q == S_WRITE);
    assign busy_o        = (state_q != S_IDLE);
    assign state_o       = state_q;
    assign ram_wr_o      = ram_wr_q;
    assign ram_address_o = ram_address_q;
    assign ram_data_o    = ram_data_q;
    assign rd_valid_o    = (count_q != 3'd0);
    assign rd_data_o     = fifo_q[rptr_q];

    assign cmd_hs   = cmd_valid_i & cmd_ready_o;
    assign wr_hs    = wr_valid_i & wr_ready_o;
    assign rd_hs    = rd_valid_o & rd_ready_i;
    assign push     = rd_pipe_q[1];
    assign inflight = {2'b00, rd_pipe_q[0]} + {2'b00, rd_pipe_q[1]};
    // Reserve a FIFO slot for every read still travelling through the RAM,
    // so a push can never find the FIFO full.
    assign can_issue = (count_q + inflight) < 3'd4;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_d        = beat_q;
        ram_wr_d      = 1'b0;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        issue         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    len_d  = cmd_len_i;
                    beat_d = '0;
                    if (cmd_wr_i) begin
                        addr_d  = cmd_addr_i;
                        state_d = S_WRITE;
                    end else begin
                        // First read address goes out on the accept edge;
                        // beat counts issued reads, so it starts at one.
                        issue         = 1'b1;
                        ram_address_d = cmd_addr_i;
                        addr_d        = cmd_addr_i + ADDR_ONE;
                        beat_d        = ADDR_ONE;
                        state_d       = (cmd_len_i == '0) ? S_DRAIN : S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (wr_hs) begin
                    ram_wr_d      = 1'b1;
                    ram_address_d = addr_q;
                    ram_data_d    = wr_data_i;
                    addr_d        = addr_q + ADDR_ONE;
                    if (beat_q == len_q) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + ADDR_ONE;
                    end
                end
            end
            S_READ: begin
                if (can_issue) begin
                    issue         = 1'b1;
                    ram_address_d = addr_q;
                    addr_d        = addr_q + ADDR_ONE;
                    beat_d        = beat_q + ADDR_ONE;
                    if (beat_q == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((inflight == 3'd0) && (count_q == 3'd0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        rd_pipe_d = {rd_pipe_q[0], issue};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            ram_wr_q      <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            rd_pipe_q     <= 2'b00;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            ram_wr_q      <= ram_wr_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            rd_pipe_q     <= rd_pipe_d;
        end
    end

    // Read-data FIFO; storage is cleared too so rd_data_o reads 0 after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wptr_q  <= 2'd0;
            rptr_q  <= 2'd0;
            count_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= ram_out_i;
                wptr_q         <= wptr_q + 2'd1;
            end
            if (rd_hs) begin
                rptr_q <= rptr_q + 2'd1;
            end
            case ({push, rd_hs})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef RAM_BURST_CSUM_EN
    logic [WIDTH-1:0] csum_q, csum_d;
    logic             csum_valid_q;
    logic             burst_done;

    // Cleared when a burst is accepted, then folds in every transferred byte.
    // Write and read handshakes never coincide, and the FIFO is empty in IDLE.
    always_comb begin
        csum_d = csum_q;
        if (cmd_hs) begin
            csum_d = '0;
        end else if (wr_hs) begin
            csum_d = csum_q ^ wr_data_i;
        end else if (rd_hs) begin
            csum_d = csum_q ^ rd_data_o;
        end
    end

    assign burst_done = (state_q != S_IDLE) && (state_d == S_IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            csum_q       <= '0;
            csum_valid_q <= 1'b0;
        end else begin
            csum_q       <= csum_d;
            csum_valid_q <= burst_done;
        end
    end

    assign csum_o       = csum_q;
    assign csum_valid_o = csum_valid_q;
`else
    assign csum_o       = '0;
    assign csum_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Testbench for ram_burst_ctrl: RAM model, directed bursts from the test
// plan, then randomized bursts with random write gaps and read backpressure.
module tb_ram_burst_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [5:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       busy, ram_wr;
  logic [5:0] ram_address;
  logic [7:0] ram_data, ram_out, csum;
  logic       csum_valid;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 0;   // 0: rd_ready high, 1: random, 2: low

  logic [7:0] ref_mem [64];
  logic [7:0] wbuf [64];
  logic [7:0] exp_q[$];
  logic [7:0] csum_exp_q[$];
  int         csum_pulses = 0;
  logic       csum_valid_prev = 1'b0;

  ram_burst_ctrl dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_wr_i     (cmd_wr),
    .cmd_addr_i   (cmd_addr),
    .cmd_len_i    (cmd_len),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .wr_data_i    (wr_data),
    .rd_valid_o   (rd_valid),
    .rd_ready_i   (rd_ready),
    .rd_data_o    (rd_data),
    .busy_o       (busy),
    .ram_wr_o     (ram_wr),
    .ram_address_o(ram_address),
    .ram_data_o   (ram_data),
    .ram_out_i    (ram_out),
    .csum_o       (csum),
    .csum_valid_o (csum_valid),
    .state_o      (dbg_state)
  );

  // ---------------- clock / RAM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single_port_ram: write at the edge, address registered, output read from
  // the registered address. Not affected by the controller reset.
  logic [7:0] ram_mem [64];
  logic [5:0] ram_areg = 6'd0;
  bit         ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= 8'(i * 37) ^ 8'h5A;
      ram_loaded <= 1'b1;
    end else if (ram_wr) begin
      ram_mem[ram_address] <= ram_data;
    end
    ram_areg <= ram_address;
  end
  assign ram_out = ram_mem[ram_areg];

  // ---------------- checking helpers ----------------
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) timeout("rd_unexpected_beat");
        else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
`ifdef RAM_BURST_CSUM_EN
      if (csum_valid) begin
        if (csum_valid_prev) timeout("csum_valid_not_one_cycle");
        if (csum_exp_q.size() == 0) timeout("csum_unexpected_strobe");
        else check("csum", 32'(csum), 32'(csum_exp_q.pop_front()));
      end
`else
      if (csum_valid || csum != 8'h00) csum_pulses++;
`endif
      csum_valid_prev <= csum_valid;
    end
  end

  // ---------------- rd_ready driver ----------------
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ($urandom_range(0, 3) != 0);
        default: rd_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic wr, input logic [5:0] addr, input logic [5:0] len);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) timeout("cmd_ready");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'($urandom);
    cmd_addr  = 6'($urandom);
    cmd_len   = 6'($urandom);
  endtask

  // Writes wbuf[0..len]; abort_beat >= 0 pulses reset while that beat is offered.
  task automatic do_write(input logic [5:0] addr, input logic [5:0] len,
                          input bit gaps, input int abort_beat);
    logic [5:0] a = addr;
    logic [7:0] x = 8'h00;
    int n;
    for (int b = 0; b <= int'(len); b++) x ^= wbuf[b];
`ifdef RAM_BURST_CSUM_EN
    if (abort_beat < 0) csum_exp_q.push_back(x);
`endif
    send_cmd(1'b1, addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      wr_valid = 1'b1;
      wr_data  = wbuf[b];
      if (b == abort_beat) rst_n = 1'b0;
      n = 0;
      while (!wr_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!wr_ready) timeout("wr_ready");
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      wr_data  = 8'($urandom);
      if (b == abort_beat) begin
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ram_wr", 32'(ram_wr), 32'd0);
        return;
      end
      ref_mem[a] = wbuf[b];
      @(negedge clk);
      check("wr_ram_wr", 32'(ram_wr), 32'd1);
      check("wr_ram_address", 32'(ram_address), 32'(a));
      check("wr_ram_data", 32'(ram_data), 32'(wbuf[b]));
      if (b == int'(len)) check("wr_idle_after_last", 32'(busy), 32'd0);
      a = a + 6'd1;
    end
  endtask

  // hold > 0: rd_ready is expected low; after hold cycles check that issuing
  // stopped with four reads outstanding, then release backpressure.
  task automatic do_read(input logic [5:0] addr, input logic [5:0] len, input int hold);
    logic [7:0] x = 8'h00;
    logic [5:0] a = addr;
    int n;
    for (int b = 0; b <= int'(len); b++) begin
      exp_q.push_back(ref_mem[a]);
      x ^= ref_mem[a];
      a = a + 6'd1;
    end
`ifdef RAM_BURST_CSUM_EN
    csum_exp_q.push_back(x);
`endif
    send_cmd(1'b0, addr, len);
    n = 1;
    @(negedge clk);
    while (!rd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rd_first_latency", 32'(n), 32'd3);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("bp_rd_valid", 32'(rd_valid), 32'd1);
      check("bp_issue_stopped", 32'(ram_address), 32'(addr + 6'd3));
      check("bp_busy", 32'(busy), 32'd1);
      rdy_mode = 0;
    end
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout("read_burst_end");
    check("rd_all_beats_seen", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] ra, rl;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = 6'd0;
    cmd_len   = 6'd0;
    wr_valid  = 1'b0;
    wr_data   = 8'd0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37) ^ 8'h5A;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_wr", 32'(ram_wr), 32'd0);
    check("rst_ram_address", 32'(ram_address), 32'd0);
    check("rst_ram_data", 32'(ram_data), 32'd0);
    check("rst_csum", 32'(csum), 32'd0);
    check("rst_csum_valid", 32'(csum_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // single beat write then read back (read accepted right after the write)
    wbuf[0] = 8'h01;
    do_write(6'd1, 6'd0, 1'b0, -1);
    do_read(6'd1, 6'd0, 0);

    // wrapping burst 62,63,0,1
    wbuf[0] = 8'h10; wbuf[1] = 8'h11; wbuf[2] = 8'h12; wbuf[3] = 8'h13;
    do_write(6'd62, 6'd3, 1'b0, -1);
    do_read(6'd62, 6'd3, 0);

    // read backpressure: 8 beats, rd_ready low for 10 cycles
    rdy_mode = 2;
    do_read(6'd20, 6'd7, 10);

    // reset during beat 2 of a 4-beat write
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    do_write(6'd40, 6'd3, 1'b0, 2);
    do_read(6'd40, 6'd3, 0);

    // checksum burst 03,02,06 -> 07
    wbuf[0] = 8'h03; wbuf[1] = 8'h02; wbuf[2] = 8'h06;
    do_write(6'd8, 6'd2, 1'b0, -1);
    do_read(6'd8, 6'd2, 0);

    // randomized bursts
    rdy_mode = 1;
    repeat (24) begin
      ra = 6'($urandom);
      rl = ($urandom_range(0, 5) == 0) ? 6'd63 : 6'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 64; i++) wbuf[i] = 8'($urandom);
        do_write(ra, rl, 1'b1, -1);
      end else begin
        do_read(ra, rl, 0);
      end
    end

    repeat (4) @(negedge clk);
    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
`ifdef RAM_BURST_CSUM_EN
    check("final_csum_q_empty", 32'(csum_exp_q.size()), 32'd0);
`else
    check("no_csum_activity", 32'(csum_pulses), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global guard against a hung run
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst access controller sitting directly upstream of `single_port_ram` (64 x 8, synchronous). It converts single-command read or write bursts with valid/ready streams into the RAM's `wr`/`address`/`data` port sequence. It also returns read data through a 4-entry output FIFO with backpressure, so client logic never drives RAM pins cycle by cycle.

## Interface
Parameters:
- `DEPTH_LOG2`, 6: RAM address width; RAM depth is 2^DEPTH_LOG2.
- `WIDTH`, 8: data width.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted this cycle when high with `cmd_valid`.
- `cmd_wr`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  6  burst start address.
- `cmd_len`  in  6  beats minus 1 (0 = 1 beat, 63 = 64 beats).
- `wr_valid` / `wr_ready` / `wr_data`  in / out / in  1/1/8  write data stream.
- `rd_valid` / `rd_ready` / `rd_data`  out / in / out  1/1/8  read data stream.
- `busy`  out  1  burst in progress (state != IDLE).
- `ram_wr`  out  1  to RAM `wr`.
- `ram_address`  out  6  to RAM `address`.
- `ram_data`  out  8  to RAM `data`.
- `ram_out`  in  8  from RAM `out`.
- `csum`  out  8  burst checksum (see Configuration).
- `csum_valid`  out  1  one-cycle checksum strobe.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE: `cmd_ready`=1. On handshake, latch addr/len and clear the beat counter.
  - `cmd_wr`=1 goes to WRITE.
  - `cmd_wr`=0 goes to READ and issues the first read address on the same edge.
- WRITE: `wr_ready`=1. Each wr handshake registers `ram_wr`<=1, `ram_address`<=addr, `ram_data`<=`wr_data`, then increments addr.
  - With no handshake, `ram_wr`<=0.
  - Handshake on beat `cmd_len` goes to IDLE on the same edge.
- READ: each issue registers `ram_wr`<=0, `ram_address`<=addr.
  - Issue is allowed only when FIFO count + in-flight reads < 4.
  - After the last issue, go to DRAIN.
- DRAIN: wait until in-flight = 0 and FIFO empty, then go to IDLE.
- RAM contract: address registered at edge E produces valid `ram_out` in the cycle after E+1. The block captures it into the FIFO at edge E+2 via a 2-stage valid shift.
- FIFO: 4 x 8. `rd_valid` = not empty and `rd_data` = head. Pop on `rd_valid & rd_ready`. Simultaneous push and pop keeps the count.
- Address arithmetic: increments modulo 64, so 63 wraps to 0 within a burst.
- `cmd_ready`, `wr_ready` are 0 outside their states. A new command cannot be accepted while `busy`.

## Timing
- Reset values (on the edge with `rst_n`=0): state IDLE, `cmd_ready` 0 while `rst_n` low, `wr_ready` 0, `rd_valid` 0, `rd_data` 0, `busy` 0, `ram_wr` 0, `ram_address` 0, `ram_data` 0, `csum` 0, `csum_valid` 0. The FIFO and in-flight pipeline are flushed.
- Reset mid-burst: abort immediately. The remaining beats are dropped and the RAM contents already written are kept.
- Write latency: with the handshake in cycle 0, `ram_wr`=1 in cycle 1 and the RAM commits at the end of cycle 1.
- Read latency: with cmd handshake in cycle 0, first `rd_valid`=1 in cycle 3. With `rd_ready` held at 1, one beat per cycle thereafter.
- Write-then-read: a read command accepted in the cycle after the last write beat returns the new data.
- `cmd_len`=0 gives a single beat. For WRITE, the cycle after the beat is already IDLE.

## Configuration
- `RAM_BURST_CSUM_EN` defined:
  - `csum` is the XOR of all bytes of the burst: bytes handshaken on `wr_*` for writes, bytes popped on `rd_*` for reads.
  - `csum_valid` pulses for one cycle in the cycle after the FSM returns to IDLE.
  - `csum` holds until the next burst starts.
- `RAM_BURST_CSUM_EN` undefined: `csum`=0 and `csum_valid`=0 permanently; no checksum logic.

## Test plan
- Write addr 1, len 0, data 0x01, then read addr 1 len 0 -> `rd_data`=0x01, with `rd_valid` in cycle 3 after read cmd handshake.
- Write addr 62, len 3, data 0x10,0x11,0x12,0x13, then read addr 62 len 3 -> 0x10,0x11,0x12,0x13. RAM addresses 62,63,0,1 (wrap).
- Read burst len 7 with `rd_ready` low for 10 cycles -> FIFO holds 4 entries and in-flight reads stop. After `rd_ready` rises, 8 bytes arrive in order with no loss or duplicate.
- `rst_n` low for 1 cycle during beat 2 of a 4-beat write -> `busy`=0, `ram_wr`=0 next cycle. Beats 0-1 remain in RAM and beat 2 is not written.
- With `RAM_BURST_CSUM_EN`: write 0x03,0x02,0x06 -> `csum`=0x07 with one-cycle `csum_valid`. Without the macro, `csum_valid` stays 0.
